chip8_sprite_drawer: RTL and testbench
======================================

CHIP8_SPRITE_DRAWER -- requirements
Module: chip8_sprite_drawer

Interface
REQ-001 SHALL have parameter CLIP, default 0: 0 = off-screen pixels wrap modulo 64/32; 1 = off-screen pixels are clipped.
REQ-002 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port start  in  1  draw request (DXYN), sampled only in IDLE.
REQ-005 SHALL have port vx  in  8  sprite X origin (register VX value).
REQ-006 SHALL have port vy  in  8  sprite Y origin (register VY value).
REQ-007 SHALL have port n  in  4  sprite height in rows (0..15).
REQ-008 SHALL have port I  in  16  sprite base address in memory.
REQ-009 SHALL have port mem_addr  out  12  sprite byte read address.
REQ-010 SHALL have port mem_readdata  in  8  memory data, valid 1 cycle after mem_addr.
REQ-011 SHALL have ports fb_x  out  6, fb_y  out  5  framebuffer pixel coordinate for read and write.
REQ-012 SHALL have port fb_readdata  in  1  pixel value, valid 1 cycle after fb_x/fb_y.
REQ-013 SHALL have ports fb_we  out  1, fb_writedata  out  1  pixel write strobe and value.
REQ-014 SHALL have ports busy  out  1, done  out  1 (1-cycle pulse), collision  out  1 (VF result, held until next start).

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, MWAIT, FBRD, FBWAIT, FBWR, FINISH.
REQ-016 IDLE: on start=1, latch vx mod 64, vy mod 32, n, I; clear collision; row=0, col=0; go FETCH (or FINISH when n=0).
REQ-017 FETCH (1 cycle): drive mem_addr = (I + row) truncated to 12 bits (wrap 0xFFF->0x000); go MWAIT.
REQ-018 MWAIT (1 cycle): latch mem_readdata as sprite byte; go FBRD.
REQ-019 FBRD: drive fb_x = (x0 + col) mod 64, fb_y = (y0 + row) mod 32; go FBWAIT.
REQ-020 FBWAIT: hold fb_x/fb_y; go FBWR.
REQ-021 FBWR: if sprite bit [7-col] = 1 and pixel enabled, assert fb_we=1, fb_writedata = ~fb_readdata; set collision if fb_readdata=1.
REQ-022 Pixel enabled: always when CLIP=0; when CLIP=1 only if x0+col < 64 and y0+row < 32 (unwrapped sum).
REQ-023 Every pixel costs exactly 3 cycles (FBRD, FBWAIT, FBWR) regardless of bit value; disabled/zero pixels never assert fb_we and never affect collision.
REQ-024 After FBWR: col<7 -> col+1, FBRD; col=7 and row<n-1 -> row+1, col=0, FETCH; else FINISH.
REQ-025 FINISH: done=1 for exactly 1 cycle; collision final; go IDLE.
REQ-026 Latency: start accepted at cycle 0 -> done at cycle 26*n+1 (n=0: done at cycle 1, collision=0, no fb/mem activity).
REQ-027 busy SHALL be 1 in every state except IDLE; start while busy is ignored.
REQ-028 fb_we SHALL be 0 in every state except FBWR; mem_addr/fb_x/fb_y hold last value when not driven.
REQ-029 start asserted in the same cycle done pulses is not sampled; it is sampled on the following cycle in IDLE.

Reset
REQ-030 reset=0 SHALL immediately (asynchronously) force IDLE, busy=0, done=0, collision=0, fb_we=0, fb_writedata=0, mem_addr=0, fb_x=0, fb_y=0.
REQ-031 reset mid-draw SHALL abort without done pulse; pixels already written are not undone.
REQ-032 After reset release, first start SHALL be accepted no earlier than the first rising edge with reset=1.

Verification
REQ-033 Blank fb, vx=0, vy=0, n=1, I=0x050, mem[0x050]=0xF0 -> fb_we on pixels (0..3,0) with writedata 1, done at cycle 27, collision=0.
REQ-034 Repeat REQ-033 draw on the now-set pixels -> pixels (0..3,0) written 0, collision=1.
REQ-035 CLIP=0, vx=62, vy=31, n=2, bytes 0xFF -> writes at x=62,63,0..5 and y=31 then y=0; done at cycle 53.
REQ-036 CLIP=1, same stimulus as REQ-035 -> only (62,31),(63,31) written; done still at cycle 53; collision=0 on blank fb.
REQ-037 vx=200, vy=40, n=0 -> done at cycle 1, no mem/fb activity; start pulsed during busy of an n=15 draw -> ignored, single done at cycle 391.
REQ-038 reset=0 at cycle 10 of an n=3 draw -> fb_we=0 and busy=0 within same cycle, no done; new draw afterwards completes normally.

Source files
------------

// File: rtl/chip8_sprite_drawer.sv
// CHIP-8 DXYN sprite engine: fetches sprite rows from memory and XORs them into a 64x32
// framebuffer one pixel at a time (read, wait, write), reporting pixel collisions.
module chip8_sprite_drawer #(
    parameter bit CLIP = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  vx,
    input  logic [7:0]  vy,
    input  logic [3:0]  n,
    input  logic [15:0] I,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_readdata,
    output logic [5:0]  fb_x,
    output logic [4:0]  fb_y,
    input  logic        fb_readdata,
    output logic        fb_we,
    output logic        fb_writedata,
    output logic        busy,
    output logic        done,
    output logic        collision
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StMwait, StFbrd, StFbwait, StFbwr, StFinish
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  x0_q;
    logic [4:0]  y0_q;
    logic [3:0]  n_q;
    logic [11:0] base_q;
    logic [3:0]  row_q;
    logic [2:0]  col_q;
    logic [7:0]  sprite_q;
    logic [11:0] addr_q;
    logic [5:0]  fbx_q;
    logic [4:0]  fby_q;
    logic        coll_q;

    logic [6:0]  x_sum;
    logic [5:0]  y_sum;
    logic        pix_on, pix_en, last_col, last_row;
    logic        unused_bits;

    assign unused_bits = ^{vx[7:6], vy[7:5], I[15:12]};

    // Unwrapped coordinates of the current pixel; the carry bits flag off-screen pixels.
    assign x_sum    = {1'b0, x0_q} + {4'b0, col_q};
    assign y_sum    = {1'b0, y0_q} + {2'b0, row_q};
    assign pix_on   = sprite_q[3'd7 - col_q];
    assign pix_en   = !CLIP || (!x_sum[6] && !y_sum[5]);
    assign last_col = (col_q == 3'd7);
    assign last_row = (({1'b0, row_q} + 5'd1) >= {1'b0, n_q});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != StIdle);
        done    = (state_q == StFinish);
        fb_we   = 1'b0;
        unique case (state_q)
            StIdle:   if (start) state_d = (n == 4'd0) ? StFinish : StFetch;
            StFetch:  state_d = StMwait;
            StMwait:  state_d = StFbrd;
            StFbrd:   state_d = StFbwait;
            StFbwait: state_d = StFbwr;
            StFbwr: begin
                fb_we = pix_on && pix_en;
                if (!last_col)      state_d = StFbrd;
                else if (!last_row) state_d = StFetch;
                else                state_d = StFinish;
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign fb_writedata = fb_we & ~fb_readdata;
    assign mem_addr     = addr_q;
    assign fb_x         = fbx_q;
    assign fb_y         = fby_q;
    assign collision    = coll_q;

    // Address and coordinate registers are loaded on entry to the state that drives them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x0_q     <= '0;
            y0_q     <= '0;
            n_q      <= '0;
            base_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            sprite_q <= '0;
            addr_q   <= '0;
            fbx_q    <= '0;
            fby_q    <= '0;
            coll_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        x0_q   <= vx[5:0];
                        y0_q   <= vy[4:0];
                        n_q    <= n;
                        base_q <= I[11:0];
                        row_q  <= '0;
                        col_q  <= '0;
                        coll_q <= 1'b0;
                        if (n != 4'd0) addr_q <= I[11:0];
                    end
                end
                StMwait: begin
                    sprite_q <= mem_readdata;
                    fbx_q    <= x_sum[5:0];
                    fby_q    <= y_sum[4:0];
                end
                StFbwr: begin
                    if (fb_we && fb_readdata) coll_q <= 1'b1;
                    if (!last_col) begin
                        col_q <= col_q + 3'd1;
                        fbx_q <= x_sum[5:0] + 6'd1;
                    end else if (!last_row) begin
                        row_q  <= row_q + 4'd1;
                        col_q  <= '0;
                        addr_q <= base_q + {8'b0, row_q} + 12'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// Drives a wrapping and a clipping drawer with identical draws and compares framebuffer,
// collision, write count and done latency against a pixel-level XOR reference model.
module tb_chip8_sprite_drawer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  vx, vy;
    logic [3:0]  n;
    logic [15:0] I;

    logic [11:0] mem_addr0, mem_addr1;
    logic [7:0]  mem_rd0, mem_rd1;
    logic [5:0]  fb_x0, fb_x1;
    logic [4:0]  fb_y0, fb_y1;
    logic        fb_rd0, fb_rd1, fb_we0, fb_we1, fb_wd0, fb_wd1;
    logic        busy0, busy1, done0, done1, coll0, coll1;

    bit [7:0] mem [4096];
    bit       fb0  [32][64];
    bit       fb1  [32][64];
    bit       ref0 [32][64];
    bit       ref1 [32][64];
    int       we_cnt0 = 0;
    int       we_cnt1 = 0;
    int       n_checks = 0;
    int       n_errors = 0;

    always #5 clk = ~clk;

    chip8_sprite_drawer #(.CLIP(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .vx(vx), .vy(vy), .n(n), .I(I),
        .mem_addr(mem_addr0), .mem_readdata(mem_rd0), .fb_x(fb_x0), .fb_y(fb_y0),
        .fb_readdata(fb_rd0), .fb_we(fb_we0), .fb_writedata(fb_wd0),
        .busy(busy0), .done(done0), .collision(coll0)
    );

    chip8_sprite_drawer #(.CLIP(1'b1)) dut_clip (
        .clk(clk), .reset(reset), .start(start), .vx(vx), .vy(vy), .n(n), .I(I),
        .mem_addr(mem_addr1), .mem_readdata(mem_rd1), .fb_x(fb_x1), .fb_y(fb_y1),
        .fb_readdata(fb_rd1), .fb_we(fb_we1), .fb_writedata(fb_wd1),
        .busy(busy1), .done(done1), .collision(coll1)
    );

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clk) begin
        mem_rd0 <= mem[mem_addr0];
        mem_rd1 <= mem[mem_addr1];
        fb_rd0  <= fb0[fb_y0][fb_x0];
        fb_rd1  <= fb1[fb_y1][fb_x1];
        if (fb_we0) begin
            fb0[fb_y0][fb_x0] <= fb_wd0;
            we_cnt0 <= we_cnt0 + 1;
        end
        if (fb_we1) begin
            fb1[fb_y1][fb_x1] <= fb_wd1;
            we_cnt1 <= we_cnt1 + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // XOR the first `limit` pixels of a sprite into both reference framebuffers.
    task automatic model_draw(input bit [7:0] x, input bit [7:0] y, input bit [3:0] h,
                              input bit [15:0] addr, input int limit,
                              output bit c0, output bit c1, output int w0, output int w1);
        int k = 0;
        c0 = 0; c1 = 0; w0 = 0; w1 = 0;
        for (int r = 0; r < int'(h); r++) begin
            bit [7:0] row_bits = mem[(int'(addr) + r) % 4096];
            for (int c = 0; c < 8; c++) begin
                int xx = int'(x) % 64 + c;
                int yy = int'(y) % 32 + r;
                if (k < limit && row_bits[7 - c]) begin
                    if (ref0[yy % 32][xx % 64]) c0 = 1;
                    ref0[yy % 32][xx % 64] = ~ref0[yy % 32][xx % 64];
                    w0++;
                    if (xx < 64 && yy < 32) begin
                        if (ref1[yy][xx]) c1 = 1;
                        ref1[yy][xx] = ~ref1[yy][xx];
                        w1++;
                    end
                end
                k++;
            end
        end
    endtask

    function automatic int fb_diff(input bit clip);
        int d = 0;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 64; x++)
                if (clip ? (fb1[y][x] != ref1[y][x]) : (fb0[y][x] != ref0[y][x])) d++;
        return d;
    endfunction

    // early=1: called at the negedge of a done cycle, start is raised during FINISH and must
    // only be taken on the following IDLE edge.
    task automatic draw(input bit [7:0] x, input bit [7:0] y, input bit [3:0] h,
                        input bit [15:0] addr, input bit early, input int poke, input string tag);
        bit   ec0, ec1;
        int   ew0, ew1, b0, b1, cyc, busy_err, idle_err;
        logic [11:0] addr_before;
        model_draw(x, y, h, addr, 1000, ec0, ec1, ew0, ew1);
        b0 = we_cnt0;
        b1 = we_cnt1;
        addr_before = mem_addr0;
        if (!early) @(negedge clk);
        vx = x; vy = y; n = h; I = addr; start = 1'b1;
        if (early) @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        busy_err = 0;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            start = (cyc == poke);
            if (busy0 !== 1'b1) busy_err++;
            if (done0 === 1'b1) break;
        end
        start = 1'b0;
        check({tag, "_latency"}, cyc, 26 * int'(h) + 1);
        check({tag, "_done_clip"}, done1, 1);
        check({tag, "_busy"}, busy_err, 0);
        check({tag, "_coll_wrap"}, coll0, ec0);
        check({tag, "_coll_clip"}, coll1, ec1);
        check({tag, "_writes_wrap"}, we_cnt0 - b0, ew0);
        check({tag, "_writes_clip"}, we_cnt1 - b1, ew1);
        check({tag, "_fb_wrap"}, fb_diff(1'b0), 0);
        check({tag, "_fb_clip"}, fb_diff(1'b1), 0);
        if (h == 4'd0) check({tag, "_mem_addr_held"}, mem_addr0, addr_before);
        if (poke > 0) begin
            idle_err = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done0 !== 1'b0 || busy0 !== 1'b0) idle_err++;
            end
            check({tag, "_no_second_done"}, idle_err, 0);
        end
    endtask

    initial begin
        bit c0, c1;
        int w0, w1, cyc, bad;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        mem[12'h050] = 8'hF0;
        mem[12'h300] = 8'hFF;
        mem[12'h301] = 8'hFF;
        mem[12'h200] = 8'hC3;
        reset = 1'b0; start = 1'b0; vx = '0; vy = '0; n = '0; I = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_coll", coll0, 0);
        check("rst_we", fb_we0, 0);
        check("rst_wd", fb_wd0, 0);
        check("rst_addr", mem_addr0, 0);
        check("rst_fbx", fb_x0, 0);
        check("rst_fby", fb_y0, 0);
        reset = 1'b1;

        draw(8'd0, 8'd0, 4'd1, 16'h0050, 1'b0, 0, "first_draw");
        draw(8'd0, 8'd0, 4'd1, 16'h0050, 1'b0, 0, "redraw");
        check("redraw_collision", coll0, 1);
        draw(8'd62, 8'd31, 4'd2, 16'h0300, 1'b0, 0, "corner");
        draw(8'd200, 8'd40, 4'd0, 16'h0123, 1'b0, 0, "zero_rows");
        draw(8'd5, 8'd7, 4'd15, 16'h0400, 1'b0, 100, "busy_start");
        draw(8'd30, 8'd10, 4'd2, 16'hFFFF, 1'b0, 0, "addr_wrap");
        draw(8'd33, 8'd3, 4'd1, 16'h0123, 1'b1, 0, "chained");

        // Reset in cycle 10 of a 3-row draw: pixels 0 and 1 of row 0 have been written.
        model_draw(8'd10, 8'd5, 4'd3, 16'h0200, 2, c0, c1, w0, w1);
        @(negedge clk);
        vx = 8'd10; vy = 8'd5; n = 4'd3; I = 16'h0200; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", busy0, 0);
        check("abort_we", fb_we0, 0);
        check("abort_addr", mem_addr0, 0);
        check("abort_fbx", fb_x0, 0);
        bad = 0;
        for (cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (done0 !== 1'b0 || done1 !== 1'b0) bad++;
        end
        check("abort_no_done", bad, 0);
        check("abort_fb_wrap", fb_diff(1'b0), 0);
        check("abort_fb_clip", fb_diff(1'b1), 0);
        reset = 1'b1;
        draw(8'd10, 8'd5, 4'd3, 16'h0200, 1'b0, 0, "after_abort");

        for (int i = 0; i < 12; i++) begin
            draw(8'($urandom), 8'($urandom), 4'($urandom_range(0, 5)), 16'($urandom),
                 1'(i % 2), 0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
